i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-master I2C register-access engine: register write (START, addr+W,
// reg, data, STOP) and register read (START, addr+W, reg, RSTART, addr+R,
// one data byte, master NACK, STOP). Every bus slot is four phases of DIV
// clocks. SCL is held low in phases 0-1 and released in phases 2-3.
// Line drives are registered from next-state values, so they always change
// together with the state and phase counters.
module i2c_master #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
    S_RSTART, S_ADDR_R, S_RDATA, S_MNACK, S_STOP
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        nack_q, nack_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic        tick;
  logic        is_byte;

  // Byte shifted out in a given transmit state.
  function automatic logic [7:0] tx_byte(input state_t st, input logic [6:0] dev,
                                         input logic [7:0] ra, input logic [7:0] wd);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_ADDR_W: b = {dev, 1'b0};
      S_REG:    b = ra;
      S_WDATA:  b = wd;
      S_ADDR_R: b = {dev, 1'b1};
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

  // Line pull-downs for a state/phase/bit position: {scl_oe, sda_oe}.
  function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph,
                                            input logic [3:0] bn, input logic [7:0] tb);
    logic scl;
    logic sda;
    scl = (st != S_IDLE) && (ph < 2'd2);
    sda = 1'b0;
    case (st)
      S_START, S_RSTART:                   sda = ph[1];
      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R:  sda = (bn < 4'd8) ? ~tb[3'd7 - bn[2:0]] : 1'b0;
      S_STOP:                              sda = (ph != 2'd3);
      default:                             sda = 1'b0;
    endcase
    return {scl, sda};
  endfunction

  // Next-state logic: slot timing, ack/data sampling, sequence control.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wd_d      = wd_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    nack_d    = nack_q;
    tick      = (div_q == DIV_M1);
    is_byte   = (state_q == S_ADDR_W) || (state_q == S_REG) ||
                (state_q == S_WDATA)  || (state_q == S_ADDR_R);

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d   = S_START;
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wd_d      = wdata;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        div_d     = 8'd0;
        phase_d   = 2'd0;
        bit_d     = 4'd0;
      end
    end else begin
      if (tick) begin
        div_d   = 8'd0;
        phase_d = phase_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end

      // Sample SDA on the last clock of phase 2 (SCL high and settled).
      if (tick && phase_q == 2'd2) begin
        if (is_byte && bit_q == 4'd8) begin
          nack_d = sda_in;
          if (sda_in) ack_err_d = 1'b1;
        end
        if (state_q == S_RDATA) rx_d = {rx_q[6:0], sda_in};
      end

      // Slot boundary: advance bit position or move to the next slot type.
      if (tick && phase_q == 2'd3) begin
        case (state_q)
          S_START: begin
            state_d = S_ADDR_W;
            bit_d   = 4'd0;
          end
          S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
            end else begin
              bit_d = 4'd0;
              if (nack_q)                  state_d = S_STOP;
              else if (state_q == S_ADDR_W) state_d = S_REG;
              else if (state_q == S_REG)    state_d = rw_q ? S_RSTART : S_WDATA;
              else if (state_q == S_WDATA)  state_d = S_STOP;
              else                          state_d = S_RDATA;
            end
          end
          S_RSTART: begin
            state_d = S_ADDR_R;
            bit_d   = 4'd0;
          end
          S_RDATA: begin
            if (bit_q == 4'd7) begin
              state_d = S_MNACK;
              bit_d   = 4'd0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
          S_MNACK: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (rw_q && !ack_err_q) rdata_d = rx_q;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    {scl_oe_d, sda_oe_d} = line_drive(state_d, phase_d, bit_d,
                                      tx_byte(state_d, dev_d, reg_d, wd_d));
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      phase_q   <= 2'd0;
      bit_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      nack_q    <= 1'b0;
      rdata_q   <= 8'h00;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      nack_q    <= nack_d;
      rdata_q   <= rdata_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  // Captured request fields and receive shifter; only meaningful while busy.
  always_ff @(posedge clk) begin
    rw_q  <= rw_d;
    dev_q <= dev_d;
    reg_q <= reg_d;
    wd_q  <= wd_d;
    rx_q  <= rx_d;
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: open-drain bus with a behavioural slave that logs
// START/STOP conditions, received bytes and the master's ack bit, plus a
// DIV=1 instance for back-to-back timing.
module tb_i2c_master;

  localparam int M_S    = 256;
  localparam int M_P    = 257;
  localparam int M_NACK = 258;
  localparam int M_ACK  = 259;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wdata, rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe, sda_in;
  logic       pull;

  logic       start1;
  logic [7:0] rdata1;
  logic       busy1, done1, ack_err1, scl_oe1, sda_oe1, sda_in1;

  assign sda_in = ~(sda_oe | pull);

  i2c_master #(.DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  i2c_master #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(1'b0), .dev_addr(7'h2A),
    .reg_addr(8'h05), .wdata(8'hA5), .rdata(rdata1), .busy(busy1), .done(done1),
    .ack_err(ack_err1), .scl_oe(scl_oe1), .sda_oe(sda_oe1), .sda_in(sda_in1)
  );

  int         total = 0;
  int         bad   = 0;
  int         nack_at;
  logic [7:0] sdata;
  int         bus_log[$];
  int         exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Behavioural slave, evaluated on the falling clock edge.
  initial begin : slave
    int         bitn;
    int         rxcount;
    logic [7:0] sh;
    logic [7:0] txb;
    logic       pscl, psda, scl, sda, first, rdreq, txm, ackbit;
    pull = 1'b0; pscl = 1'b1; psda = 1'b1; bitn = 0; rxcount = 0;
    sh = 8'h00; txb = 8'h00; first = 1'b0; rdreq = 1'b0; txm = 1'b0; ackbit = 1'b0;
    forever begin
      @(negedge clk);
      scl = ~scl_oe;
      sda = ~(sda_oe | pull);
      if (!rst_n) begin
        pull = 1'b0; txm = 1'b0; bitn = 0; first = 1'b0; rdreq = 1'b0; rxcount = 0;
      end else if (scl && psda && !sda) begin
        bus_log.push_back(M_S);
        bitn = 0; first = 1'b1; txm = 1'b0; pull = 1'b0;
      end else if (scl && pscl && !psda && sda) begin
        bus_log.push_back(M_P);
        bitn = 0; txm = 1'b0; pull = 1'b0; rxcount = 0;
      end else if (scl && !pscl) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sda};
          bitn++;
        end else if (bitn == 8) begin
          ackbit = sda;
          bitn = 9;
        end
      end else if (!scl && pscl) begin
        if (bitn == 8) begin
          if (txm) pull = 1'b0;
          else begin
            bus_log.push_back(int'(sh));
            rxcount++;
            pull = (rxcount != nack_at);
            rdreq = first & sh[0];
            first = 1'b0;
          end
        end else if (bitn == 9) begin
          bitn = 0;
          if (txm) begin
            bus_log.push_back(ackbit ? M_NACK : M_ACK);
            txm = 1'b0; pull = 1'b0;
          end else if (rdreq && pull) begin
            txm = 1'b1; txb = sdata; pull = ~txb[7];
          end else begin
            pull = 1'b0;
          end
        end else if (txm) begin
          pull = ~txb[3'(7 - bitn)];
        end
      end
      pscl = scl;
      psda = sda;
    end
  end

  // Reference: expected bus events for a request and a slave NACKing byte nk.
  task automatic build_exp(input bit rwv, input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] w, input int nk);
    int b[3];
    int n;
    exp_q.delete();
    b[0] = int'({d, 1'b0});
    b[1] = int'(r);
    b[2] = rwv ? int'({d, 1'b1}) : int'(w);
    n = (nk != 0) ? nk : 3;
    exp_q.push_back(M_S);
    for (int i = 0; i < n; i++) begin
      if (rwv && i == 2) exp_q.push_back(M_S);
      exp_q.push_back(b[i]);
    end
    if (rwv && nk == 0) exp_q.push_back(M_NACK);
    exp_q.push_back(M_P);
  endtask

  function automatic int model_slots(input bit rwv, input int nk);
    int n;
    n = (nk != 0) ? nk : 3;
    return 1 + 9 * n + ((rwv && n == 3) ? 1 : 0) + ((rwv && nk == 0) ? 9 : 0) + 1;
  endfunction

  task automatic check_bus(input string tag);
    int n;
    n = (bus_log.size() > exp_q.size()) ? bus_log.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_bus%0d", tag, i),
            (i < bus_log.size()) ? bus_log[i] : -1,
            (i < exp_q.size()) ? exp_q[i] : -1);
  endtask

  task automatic do_txn(input bit rwv, input logic [6:0] d, input logic [7:0] r,
                        input logic [7:0] w, input int nk, input logic [7:0] sd,
                        input int pulse_at, output int lat, output logic err,
                        output logic [7:0] rd);
    int k;
    nack_at = nk;
    sdata   = sd;
    bus_log.delete();
    @(negedge clk);
    rw = rwv; dev_addr = d; reg_addr = r; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rw = ~rwv; dev_addr = ~d; reg_addr = ~r; wdata = ~w;
    check("busy_rise", busy, 1);
    check("err_clear", ack_err, 0);
    k = 0;
    lat = -1;
    while (k < 1000 && lat < 0) begin
      @(negedge clk);
      k++;
      start = (k == pulse_at);
      if (done) lat = k;
    end
    err = ack_err;
    rd  = rdata;
    check("busy_fall", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("lines_idle", {scl_oe, sda_oe}, 0);
  endtask

  typedef struct {
    bit         rw;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [7:0] sd;
    int         nk;
    int         slots;
    bit         err;
    bit         chk_rd;
    logic [7:0] rd;
  } vec_t;

  initial begin : main
    vec_t       tbl[6];
    int         lat;
    logic       err;
    logic [7:0] rd;
    logic [7:0] rd_model;
    int         dones;
    int         k1, k2, k;
    bit         rwr;
    logic [6:0] dr;
    logic [7:0] rr, wr, sr;
    int         nkr;

    tbl[0] = '{0, 7'h2A, 8'h05, 8'hA5, 8'h00, 0, 29, 0, 0, 8'h00};
    tbl[1] = '{1, 7'h2A, 8'h10, 8'h00, 8'h3C, 0, 39, 0, 1, 8'h3C};
    tbl[2] = '{0, 7'h2A, 8'h05, 8'hA5, 8'h00, 1, 11, 1, 0, 8'h00};
    tbl[3] = '{0, 7'h11, 8'hF0, 8'h0F, 8'h00, 2, 20, 1, 0, 8'h00};
    tbl[4] = '{1, 7'h7F, 8'h00, 8'h00, 8'hC3, 3, 30, 1, 0, 8'h00};
    tbl[5] = '{1, 7'h01, 8'hFF, 8'h00, 8'h81, 0, 39, 0, 1, 8'h81};

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; sda_in1 = 1'b0;
    rw = 1'b0; dev_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
    nack_at = 0; sdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", ack_err, 0);
    check("rst_lines", {scl_oe, sda_oe}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i].rw, tbl[i].dev, tbl[i].ra, tbl[i].wd, tbl[i].nk, tbl[i].sd, -1, lat, err, rd);
      check($sformatf("v%0d_latency", i), lat, tbl[i].slots * 16);
      check($sformatf("v%0d_ack_err", i), err, tbl[i].err);
      if (tbl[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      build_exp(tbl[i].rw, tbl[i].dev, tbl[i].ra, tbl[i].wd, tbl[i].nk);
      check_bus($sformatf("v%0d", i));
    end
    rd_model = 8'h81;

    for (int n = 0; n < 8; n++) begin
      rwr = 1'($urandom_range(0, 1));
      dr  = 7'($urandom);
      rr  = 8'($urandom);
      wr  = 8'($urandom);
      sr  = 8'($urandom);
      nkr = rwr ? 0 : int'($urandom_range(0, 3));
      do_txn(rwr, dr, rr, wr, nkr, sr, -1, lat, err, rd);
      if (rwr) rd_model = sr;
      check($sformatf("r%0d_latency", n), lat, model_slots(rwr, nkr) * 16);
      check($sformatf("r%0d_ack_err", n), err, (nkr != 0) ? 1 : 0);
      check($sformatf("r%0d_rdata", n), rd, rd_model);
      build_exp(rwr, dr, rr, wr, nkr);
      check_bus($sformatf("r%0d", n));
    end

    // A start pulse mid-write must be ignored and not queued.
    do_txn(0, 7'h2A, 8'h05, 8'hA5, 0, 8'h00, 100, lat, err, rd);
    check("ign_latency", lat, 464);
    check("ign_ack_err", err, 0);
    build_exp(0, 7'h2A, 8'h05, 8'hA5, 0);
    check_bus("ign");
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("ign_no_requeue", dones, 0);

    // Reset in the middle of a read, with start held during reset.
    nack_at = 0; sdata = 8'h3C;
    @(negedge clk);
    rw = 1'b1; dev_addr = 7'h2A; reg_addr = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < 200; k++) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("mrst_lines", {scl_oe, sda_oe}, 0);
    check("mrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("mrst_start_ignored", busy, 0);
    dones = 0;
    repeat (700) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mrst_no_done", dones, 0);
    check("mrst_rdata", rdata, 8'h00);

    // DIV=1 back-to-back writes with start held high.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    check("b2b_busy1", busy1, 1);
    k = 0; k1 = -1; k2 = -1;
    while (k < 400 && k2 < 0) begin
      @(negedge clk);
      k++;
      if (done1 && k1 < 0) begin
        k1 = k;
        @(negedge clk);
        k++;
        start1 = 1'b0;
        check("b2b_reaccept", busy1, 1);
      end else if (done1) begin
        k2 = k;
      end
    end
    check("b2b_done1", k1, 116);
    check("b2b_done2", k2, 116 + 1 + 116);
    check("b2b_ack_err", ack_err1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
